// File: rtl/exibidor_bcd_7seg_pkg.sv
// Shared constants for the BCD seven-segment display block: segment patterns (active-high, gfedcba),
// FSM state encoding and the BCD register sizing helper.
package pkg_exibidor;

    localparam logic [6:0] SEG_0       = 7'b0111111;
    localparam logic [6:0] SEG_1       = 7'b0000110;
    localparam logic [6:0] SEG_2       = 7'b1011011;
    localparam logic [6:0] SEG_3       = 7'b1001111;
    localparam logic [6:0] SEG_4       = 7'b1100110;
    localparam logic [6:0] SEG_5       = 7'b1101101;
    localparam logic [6:0] SEG_6       = 7'b1111101;
    localparam logic [6:0] SEG_7       = 7'b0000111;
    localparam logic [6:0] SEG_8       = 7'b1111111;
    localparam logic [6:0] SEG_9       = 7'b1101111;
    localparam logic [6:0] SEG_MENOS   = 7'b1000000;
    localparam logic [6:0] SEG_E       = 7'b1111001;
    localparam logic [6:0] SEG_APAGADO = 7'b0000000;

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        DESLOCA  = 2'd1,
        FINALIZA = 2'd2
    } estado_t;

    // Decimal digits needed to hold any WIDTH-bit unsigned value (log10(2) ~ 0.3).
    function automatic int n_bcd(input int width);
        return (width * 3) / 10 + 1;
    endfunction

endpackage

// File: rtl/exibidor_bcd_7seg_if.sv
// Start/value request and display result bundle between a value source and the 7-seg converter.
// master drives the request, slave (the converter) drives status and segments.
interface exibidor_bcd_7seg_if #(
    parameter int WIDTH    = 32,
    parameter int N_DIGITS = 8
);
    logic                  start;
    logic [WIDTH-1:0]      valor;
    logic                  com_sinal;
    logic                  busy;
    logic                  done;
    logic                  overflow;
    logic [7*N_DIGITS-1:0] segs;

    modport master (
        output start, valor, com_sinal,
        input  busy, done, overflow, segs
    );

    modport slave (
        input  start, valor, com_sinal,
        output busy, done, overflow, segs
    );
endinterface

// File: rtl/exibidor_bcd_7seg_decodificador_7seg.sv
// Purpose: one BCD nibble to an active-high gfedcba segment pattern; codes above 9 show blank.
// Latency: combinational.
// Backpressure: none.
module decodificador_7seg
    import pkg_exibidor::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);
    always_comb begin
        seg = SEG_APAGADO;
        case (bcd)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_APAGADO;
        endcase
    end
endmodule

// File: rtl/exibidor_bcd_7seg.sv
// Purpose: sequential double-dabble binary-to-decimal converter driving N_DIGITS seven-segment displays.
// Latency: done rises WIDTH+2 cycles after the edge that samples start; segs/overflow update on that edge.
// Backpressure: start is accepted only while busy=0; requests while busy are dropped, not queued.
module exibidor_bcd_7seg
    import pkg_exibidor::*;
#(
    parameter int WIDTH           = 32,
    parameter int N_DIGITS        = 8,
    parameter int SEG_ATIVO_BAIXO = 1
) (
    input logic                clock,
    input logic                reset_n,
    exibidor_bcd_7seg_if.slave bus
);
    localparam int ND = n_bcd(WIDTH);
    localparam int BW = 4 * ND;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [7*N_DIGITS-1:0] MASCARA = (SEG_ATIVO_BAIXO != 0) ? '1 : '0;

    estado_t               estado, prox;
    logic [WIDTH-1:0]      bin_r;
    logic [BW-1:0]         bcd_r;
    logic [CW-1:0]         cnt;
    logic                  neg_r;
    logic                  done_r;
    logic                  ovf_r;
    logic [7*N_DIGITS-1:0] segs_r;

    logic [BW-1:0]         bcd_adj;
    logic [6:0]            dec_seg [N_DIGITS];
    logic [7*N_DIGITS-1:0] fmt_segs;
    logic                  fmt_ovf;
    int                    sig;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) estado <= OCIOSO;
        else          estado <= prox;
    end

    // DESLOCA lingers one extra cycle after the last shift so done lands at WIDTH+2.
    always_comb begin
        prox = estado;
        case (estado)
            OCIOSO:   if (bus.start) prox = DESLOCA;
            DESLOCA:  if (cnt == CW'(WIDTH)) prox = FINALIZA;
            FINALIZA: prox = OCIOSO;
            default:  prox = OCIOSO;
        endcase
    end

    always_comb begin
        bcd_adj = bcd_r;
        for (int k = 0; k < ND; k++) begin
            if (bcd_r[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_r[4*k +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bin_r  <= '0;
            bcd_r  <= '0;
            cnt    <= '0;
            neg_r  <= 1'b0;
            done_r <= 1'b0;
            ovf_r  <= 1'b0;
            segs_r <= {N_DIGITS{SEG_APAGADO}} ^ MASCARA;
        end else begin
            done_r <= 1'b0;
            case (estado)
                OCIOSO: if (bus.start) begin
                    neg_r <= bus.com_sinal & bus.valor[WIDTH-1];
                    bin_r <= (bus.com_sinal & bus.valor[WIDTH-1]) ? -bus.valor : bus.valor;
                    bcd_r <= '0;
                    cnt   <= '0;
                end
                DESLOCA: if (cnt != CW'(WIDTH)) begin
                    bcd_r <= {bcd_adj[BW-2:0], bin_r[WIDTH-1]};
                    bin_r <= {bin_r[WIDTH-2:0], 1'b0};
                    cnt   <= cnt + 1'b1;
                end
                FINALIZA: begin
                    done_r <= 1'b1;
                    ovf_r  <= fmt_ovf;
                    segs_r <= fmt_segs ^ MASCARA;
                end
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < N_DIGITS; g++) begin : g_dig
        if (g < ND) begin : g_dec
            decodificador_7seg u_dec (
                .bcd (bcd_r[4*g +: 4]),
                .seg (dec_seg[g])
            );
        end else begin : g_vazio
            assign dec_seg[g] = SEG_APAGADO;
        end
    end

    // sig = position of the most significant nonzero digit plus one; a zero value still shows one digit.
    always_comb begin
        sig = 1;
        for (int k = 0; k < ND; k++) begin
            if (bcd_r[4*k +: 4] != 4'd0) sig = k + 1;
        end
        fmt_ovf  = (sig + (neg_r ? 1 : 0)) > N_DIGITS;
        fmt_segs = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (fmt_ovf)              fmt_segs[7*i +: 7] = SEG_E;
            else if (i < sig)         fmt_segs[7*i +: 7] = dec_seg[i];
            else if (neg_r && i == sig) fmt_segs[7*i +: 7] = SEG_MENOS;
            else                      fmt_segs[7*i +: 7] = SEG_APAGADO;
        end
    end

    assign bus.busy     = (estado != OCIOSO);
    assign bus.done     = done_r;
    assign bus.overflow = ovf_r;
    assign bus.segs     = segs_r;
endmodule

// File: tb/tb_exibidor_bcd_7seg.sv
// Bench for exibidor_bcd_7seg: decimal-arithmetic reference model compared every cycle, plus literal pins.
module tb_exibidor_bcd_7seg;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    exibidor_bcd_7seg_if #(.WIDTH(32), .N_DIGITS(8)) bus ();

    exibidor_bcd_7seg #(.WIDTH(32), .N_DIGITS(8), .SEG_ATIVO_BAIXO(1)) dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_done  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Active-low glyphs: 0-9, 10 '-', 11 blank, 12 'E'.
    function automatic logic [6:0] glyph(input int d);
        case (d)
            0: return 7'b1000000;  1: return 7'b1111001;
            2: return 7'b0100100;  3: return 7'b0110000;
            4: return 7'b0011001;  5: return 7'b0010010;
            6: return 7'b0000010;  7: return 7'b1111000;
            8: return 7'b0000000;  9: return 7'b0010000;
            10: return 7'b0111111; 12: return 7'b0000110;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic void fmt(input logic [31:0] v, input logic s,
                                output logic [55:0] sg, output logic ov);
        longint mag;
        int     dg [12];
        int     n;
        bit     neg;
        neg = s && v[31];
        mag = neg ? (64'sh1_0000_0000 - longint'(v)) : longint'(v);
        n = 0;
        do begin
            dg[n] = int'(mag % 10);
            mag   = mag / 10;
            n++;
        end while (mag != 0);
        ov = (n + (neg ? 1 : 0)) > 8;
        for (int i = 0; i < 8; i++) begin
            if (ov)                 sg[7*i +: 7] = glyph(12);
            else if (i < n)         sg[7*i +: 7] = glyph(dg[i]);
            else if (neg && i == n) sg[7*i +: 7] = glyph(10);
            else                    sg[7*i +: 7] = glyph(11);
        end
    endfunction

    // Model: m_cnt counts cycles since acceptance; the 34th edge after acceptance publishes the result.
    int          m_cnt;
    logic [31:0] m_val;
    logic        m_sig;
    logic        m_done, m_ovf;
    logic [55:0] m_segs;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt = 0; m_done = 0; m_ovf = 0; m_segs = '1;
        end else begin
            m_done = 0;
            if (m_cnt != 0) begin
                if (m_cnt == 34) begin
                    m_done = 1;
                    fmt(m_val, m_sig, m_segs, m_ovf);
                    m_cnt = 0;
                end else m_cnt++;
            end else if (bus.start) begin
                m_cnt = 1; m_val = bus.valor; m_sig = bus.com_sinal;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy", bus.busy, m_cnt != 0);
            chk("done", bus.done, m_done);
            chk("overflow", bus.overflow, m_ovf);
            chk("segs", bus.segs, m_segs);
            if (bus.done) n_done++;
        end
    end

    task automatic start_val(input logic [31:0] v, input logic s);
        @(negedge clk);
        bus.start = 1'b1; bus.valor = v; bus.com_sinal = s;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!bus.done && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        if (!bus.done) begin
            n_tests++; n_fail++;
            $display("FAIL done_timeout: got no done after %0d cycles, expected done", cyc);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc, d0;
        logic [31:0] v;
        logic        s;
        logic [55:0] es;
        logic        eo;

        bus.start = 1'b0; bus.valor = '0; bus.com_sinal = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_segs", bus.segs, 56'hFF_FFFF_FFFF_FFFF);
        repeat (2) @(negedge clk);
        #3 rst_n = 1'b1;

        // Pin the model against hand-derived glyph strings.
        fmt(32'd12345678, 1'b0, es, eo);
        chk("model_12345678", es, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                   7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000});
        fmt(32'hFFFF_FFFF, 1'b1, es, eo);
        chk("model_minus1", {eo, es}, {1'b0, {6{7'b1111111}}, 7'b0111111, 7'b1111001});

        // Reset mid-conversion takes effect without a clock edge.
        start_val(32'd123, 1'b0);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", bus.busy, 1'b0);
        chk("midrst_done", bus.done, 1'b0);
        chk("midrst_ovf", bus.overflow, 1'b0);
        chk("midrst_segs", bus.segs, 56'hFF_FFFF_FFFF_FFFF);
        @(negedge clk);
        #3 rst_n = 1'b1;

        start_val(32'd0, 1'b0);
        wait_done(cyc);
        chk("zero_lat", cyc, 34);
        chk("zero_segs", bus.segs, {{7{7'b1111111}}, 7'b1000000});
        chk("zero_ovf", bus.overflow, 1'b0);

        start_val(32'd12345678, 1'b0);
        wait_done(cyc);
        chk("d8_dig0", bus.segs[6:0], 7'b0000000);
        chk("d8_dig7", bus.segs[55:49], 7'b1111001);

        start_val(32'hFFFF_FFFF, 1'b1);
        wait_done(cyc);
        chk("neg1_segs", bus.segs, {{6{7'b1111111}}, 7'b0111111, 7'b1111001});
        start_val(32'hFFFF_FFFF, 1'b0);
        wait_done(cyc);
        chk("umax_ovf", bus.overflow, 1'b1);
        chk("umax_segs", bus.segs, {8{7'b0000110}});

        v = -32'sd9999999;
        start_val(v, 1'b1);
        wait_done(cyc);
        chk("n9999999_ovf", bus.overflow, 1'b0);
        chk("n9999999_segs", bus.segs, {7'b0111111, {7{7'b0010000}}});
        v = -32'sd10000000;
        start_val(v, 1'b1);
        wait_done(cyc);
        chk("n10000000_ovf", bus.overflow, 1'b1);

        // Start while busy is dropped; start in the done cycle is taken.
        @(posedge clk); #1 d0 = n_done;
        start_val(32'd42, 1'b0);
        repeat (8) @(negedge clk);
        start_val(32'd777, 1'b0);
        wait_done(cyc);
        chk("ign_segs", bus.segs, {{6{7'b1111111}}, 7'b0011001, 7'b0100100});
        bus.start = 1'b1; bus.valor = 32'd1234; bus.com_sinal = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(cyc);
        chk("b2b_lat", cyc, 34);
        chk("b2b_segs", bus.segs, {{4{7'b1111111}}, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001});
        @(posedge clk); #1;
        chk("done_pulses", n_done - d0, 2);

        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 3))
                0: begin v = $urandom; s = 1'($urandom_range(0, 1)); end
                1: begin v = $urandom_range(0, 99999999); s = 1'($urandom_range(0, 1)); end
                2: begin v = -$urandom_range(0, 9999999); s = 1'b1; end
                default: begin
                    case ($urandom_range(0, 3))
                        0: v = 32'h8000_0000;
                        1: v = 32'd99999999;
                        2: v = 32'd100000000;
                        default: v = 32'hFFFF_FFF6;
                    endcase
                    s = 1'($urandom_range(0, 1));
                end
            endcase
            start_val(v, s);
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(0, 25)) @(negedge clk);
                bus.start = 1'b1; bus.valor = $urandom; bus.com_sinal = 1'($urandom_range(0, 1));
                @(negedge clk);
                bus.start = 1'b0;
                wait_done(cyc);
            end else begin
                wait_done(cyc);
                chk("rand_lat", cyc, 34);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
